mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, giving the byte-addressed storage size (power of two, at least 4).
REQ-002 SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_wenable, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, XLEN bits: byte address.
REQ-009 SHALL have port req_wwidth, input, 2 bits: access width; write_byte=00, write_half=01, write_word=10, 11 is illegal.
REQ-010 SHALL have port req_wdata, input, XLEN bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, XLEN bits: load data, zero-extended to XLEN; 0 for stores and errors.
REQ-014 SHALL have port rsp_error, output, 1 bit: the request was misaligned, out of range or had an illegal width.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCESS, RESPOND.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid && req_ready, moving IDLE->ACCESS.
REQ-017 SHALL register addr, wenable, wwidth and wdata at acceptance; later changes on the req_* inputs do not affect the transaction.
REQ-018 SHALL spend exactly one cycle in ACCESS, then move to RESPOND, performing the storage access on the ACCESS->RESPOND edge.
REQ-019 SHALL assert rsp_valid in RESPOND only, starting 2 cycles after the acceptance edge; minimum request-to-request spacing is 3 cycles.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_error stable in RESPOND until rsp_ready=1, then move RESPOND->IDLE on that edge.
REQ-021 SHALL order bytes little-endian: byte k of the data maps to address addr+k.
REQ-022 SHALL, for a store, write only the low 1/2/4 bytes of wdata for byte/half/word; other bytes are unchanged.
REQ-023 SHALL, for a load, return the low 1/2/4 bytes at addr, zero-extended; sign extension is the initiator's job.
REQ-024 SHALL flag an error when a half access has addr[0]!=0, or a word access has addr[1:0]!=0.
REQ-025 SHALL flag an error when addr + width_bytes > DEPTH_BYTES, computed without XLEN overflow wrap.
REQ-026 SHALL flag an error when wwidth=11.
REQ-027 SHALL make an errored store modify no storage, and an errored load return rsp_rdata=0; either way it still completes the handshake.
REQ-028 SHALL make a store followed by a load of the same address return the new data; there is no hazard window.

Reset
REQ-029 SHALL, on reset, go to IDLE with rsp_valid=0, rsp_rdata=0, rsp_error=0, and req_ready=1 in the first cycle after reset.
REQ-030 SHALL give reset priority over every transition; a store whose ACCESS edge coincides with reset is not committed.
REQ-031 SHALL discard any pending response on reset; the initiator reissues the request.
REQ-032 SHALL NOT clear storage contents on reset.

Verification
REQ-033 Store word 0x12345678 at 0x0, then load word 0x0 -> rsp_rdata=0x12345678, rsp_error=0, rsp_valid 2 cycles after each acceptance.
REQ-034 Store byte 0xAB at 0x1 over word 0x12345678, then load word 0x0 -> 0x1234AB78; load half 0x0 -> 0x0000AB78.
REQ-035 Load half at 0x3, or store word at 0x2 -> rsp_error=1 and rsp_rdata=0; a following word load at 0x0 shows the contents unchanged.
REQ-036 Word access at DEPTH_BYTES-4 -> ok; at DEPTH_BYTES, or at 0xFFFFFFFC -> rsp_error=1.
REQ-037 Hold rsp_ready=0 for 5 cycles with a new req_valid asserted -> rsp fields stable, req_ready=0 throughout; the new request is accepted only after the response handshake.
REQ-038 Assert reset in the ACCESS cycle of store word 0xDEADBEEF at 0x8 (0x8 previously 0x0) -> rsp_valid=0 next cycle, a later load at 0x8 returns 0x0.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressed scratch memory behind a valid/ready request/response handshake.
// Each request takes one ACCESS cycle, then holds its response until rsp_ready.
module mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wenable,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_wwidth,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wenable_q;
  logic [1:0]      wwidth_q;

  logic [7:0]      mem [DEPTH_BYTES];

  logic [3:0]      byte_en;
  logic [2:0]      nbytes;
  logic            bad_width;
  logic            misaligned;
  logic            out_of_range;
  logic            access_error;
  logic [XLEN:0]   end_addr;
  logic [AW-1:0]   base_idx;
  logic [XLEN-1:0] load_data;

  // Decode the captured request; the extra end_addr bit keeps the range check from wrapping.
  always_comb begin
    byte_en    = 4'b0000;
    nbytes     = 3'd0;
    bad_width  = 1'b0;
    misaligned = 1'b0;
    case (wwidth_q)
      2'b00: begin
        byte_en = 4'b0001;
        nbytes  = 3'd1;
      end
      2'b01: begin
        byte_en    = 4'b0011;
        nbytes     = 3'd2;
        misaligned = addr_q[0];
      end
      2'b10: begin
        byte_en    = 4'b1111;
        nbytes     = 3'd4;
        misaligned = |addr_q[1:0];
      end
      default: bad_width = 1'b1;
    endcase
    end_addr     = {1'b0, addr_q} + (XLEN+1)'(nbytes);
    out_of_range = end_addr > (XLEN+1)'(DEPTH_BYTES);
    access_error = bad_width | misaligned | out_of_range;
  end

  assign base_idx = addr_q[AW-1:0];

  always_comb begin
    load_data = '0;
    for (int k = 0; k < 4; k++) begin
      load_data[8*k +: 8] = byte_en[k] ? mem[base_idx + AW'(k)] : 8'h00;
    end
  end

  // Storage is never reset; a reset on the ACCESS edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && wenable_q && !access_error) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[base_idx + AW'(k)] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) begin
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
      wenable_q <= req_wenable;
      wwidth_q  <= req_wwidth;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ACCESS) begin
        rsp_error <= access_error;
        rsp_rdata <= (access_error || wenable_q) ? '0 : load_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ACCESS;
      end
      ACCESS: state_next = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: handshake timing, byte lanes, error cases,
// response backpressure and reset in the middle of a store.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wenable;
  logic [31:0] req_addr;
  logic [1:0]  req_wwidth;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int total = 0;
  int bad   = 0;

  mem_responder #(.DEPTH_BYTES(1024), .XLEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wenable(req_wenable),
    .req_addr   (req_addr),
    .req_wwidth (req_wwidth),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction; inputs are scrambled after acceptance to prove they were captured.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [1:0] width, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
    int waited;
    waited      = 0;
    req_wenable = we;
    req_addr    = addr;
    req_wwidth  = width;
    req_wdata   = wdata;
    req_valid   = 1'b1;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid   = 1'b0;
    req_addr    = ~addr;
    req_wdata   = ~wdata;
    req_wenable = ~we;
    req_wwidth  = 2'b11;
    checkOutput({tag, ".access"}, 32'(rsp_valid), 32'd0);
    tick();
    checkOutput({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    rdata     = rsp_rdata;
    err       = rsp_error;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic expectTxn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] width, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    applyStimulus(tag, we, addr, width, wdata, rd, er);
    checkOutput({tag, ".rdata"}, rd, exp_rdata);
    checkOutput({tag, ".error"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_wenable = 1'b0;
    req_addr    = 32'h0;
    req_wwidth  = 2'b00;
    req_wdata   = 32'h0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset.rsp_error", 32'(rsp_error), 32'd0);

    expectTxn("st_w0",       1'b1, 32'h0, 2'b10, 32'h12345678, 32'h0, 1'b0);
    expectTxn("ld_w0",       1'b0, 32'h0, 2'b10, 32'h0, 32'h12345678, 1'b0);
    expectTxn("st_b1",       1'b1, 32'h1, 2'b00, 32'hFFFFFFAB, 32'h0, 1'b0);
    expectTxn("ld_w0_b",     1'b0, 32'h0, 2'b10, 32'h0, 32'h1234AB78, 1'b0);
    expectTxn("ld_h0",       1'b0, 32'h0, 2'b01, 32'h0, 32'h0000AB78, 1'b0);
    expectTxn("ld_b3",       1'b0, 32'h3, 2'b00, 32'h0, 32'h00000012, 1'b0);

    expectTxn("ld_h3_mis",   1'b0, 32'h3, 2'b01, 32'h0, 32'h0, 1'b1);
    expectTxn("st_w2_mis",   1'b1, 32'h2, 2'b10, 32'hCAFEBABE, 32'h0, 1'b1);
    expectTxn("ld_w0_keep",  1'b0, 32'h0, 2'b10, 32'h0, 32'h1234AB78, 1'b0);

    expectTxn("st_w_top",    1'b1, 32'd1020, 2'b10, 32'hA5A5A5A5, 32'h0, 1'b0);
    expectTxn("ld_w_top",    1'b0, 32'd1020, 2'b10, 32'h0, 32'hA5A5A5A5, 1'b0);
    expectTxn("ld_b_last",   1'b0, 32'd1023, 2'b00, 32'h0, 32'h000000A5, 1'b0);
    expectTxn("ld_h_last",   1'b0, 32'd1022, 2'b01, 32'h0, 32'h0000A5A5, 1'b0);
    expectTxn("ld_w_depth",  1'b0, 32'd1024, 2'b10, 32'h0, 32'h0, 1'b1);
    expectTxn("st_w_depth",  1'b1, 32'd1024, 2'b10, 32'h55555555, 32'h0, 1'b1);
    expectTxn("ld_b_depth",  1'b0, 32'd1024, 2'b00, 32'h0, 32'h0, 1'b1);
    expectTxn("ld_w_wrap",   1'b0, 32'hFFFFFFFC, 2'b10, 32'h0, 32'h0, 1'b1);

    expectTxn("st_w4",       1'b1, 32'h4, 2'b10, 32'h11223344, 32'h0, 1'b0);
    expectTxn("ld_w11",      1'b0, 32'h4, 2'b11, 32'h0, 32'h0, 1'b1);
    expectTxn("st_w11",      1'b1, 32'h4, 2'b11, 32'hFFFFFFFF, 32'h0, 1'b1);
    expectTxn("ld_w4_keep",  1'b0, 32'h4, 2'b10, 32'h0, 32'h11223344, 1'b0);

    // Backpressure: response held for 5 cycles while a second request waits.
    req_wenable = 1'b0;
    req_addr    = 32'h0;
    req_wwidth  = 2'b10;
    req_valid   = 1'b1;
    checkOutput("bp.ready", 32'(req_ready), 32'd1);
    tick();
    req_wwidth = 2'b01;
    checkOutput("bp.access", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp.hold_rdata", rsp_rdata, 32'h1234AB78);
      checkOutput("bp.hold_error", 32'(rsp_error), 32'd0);
      checkOutput("bp.hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp.released_ready", 32'(req_ready), 32'd1);
    checkOutput("bp.released_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("bp.second_access", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("bp.second_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp.second_rdata", rsp_rdata, 32'h0000AB78);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset lands on the ACCESS edge of a store: nothing may be written.
    expectTxn("st_w8_zero",  1'b1, 32'h8, 2'b10, 32'h00000000, 32'h0, 1'b0);
    req_wenable = 1'b1;
    req_addr    = 32'h8;
    req_wwidth  = 2'b10;
    req_wdata   = 32'hDEADBEEF;
    req_valid   = 1'b1;
    checkOutput("rst.ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst.req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst.rsp_rdata", rsp_rdata, 32'h0);
    expectTxn("ld_w8_after", 1'b0, 32'h8, 2'b10, 32'h0, 32'h0, 1'b0);
    expectTxn("ld_w0_kept",  1'b0, 32'h0, 2'b10, 32'h0, 32'h1234AB78, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
